// File: rtl/music_pkg.sv
// Shared definitions for the song controller: state encoding, default
// index widths, ROM field widths and the note payload handed to the player.
package music_pkg;

  localparam int unsigned SONG_W_DEF  = 2;
  localparam int unsigned NOTE_W_DEF  = 5;
  localparam int unsigned NOTE_CODE_W = 6;
  localparam int unsigned DUR_W       = 6;

  typedef enum logic [2:0] {
    S_PAUSED  = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD    = 3'd2,
    S_PLAYING = 3'd3,
    S_END     = 3'd4
  } state_e;

  // Note payload presented to the note player.
  typedef struct packed {
    logic [NOTE_CODE_W-1:0] note;
    logic [DUR_W-1:0]       duration;
  } note_t;

endpackage : music_pkg

// File: rtl/song_controller.sv
// Song sequencer: walks a song ROM note by note, hands each note to the note
// player, and handles play/pause and skip-to-next-song requests.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   play, next, note_done  one-cycle request pulses
//   rom_note, rom_duration ROM data, valid one cycle after rom_addr
//   rom_addr               {song_idx, note_idx}, combinational from registers
//   note, duration         registered note payload for the player
//   load_new_note          pulse: note/duration freshly loaded
//   playing                high in every state except PAUSED
//   song_end               pulse: song finished on its own
//   song                   current song index
module song_controller
  import music_pkg::*;
#(
  parameter int unsigned SONG_W = SONG_W_DEF,
  parameter int unsigned NOTE_W = NOTE_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     play,
  input  logic                     next,
  input  logic                     note_done,
  input  logic [NOTE_CODE_W-1:0]   rom_note,
  input  logic [DUR_W-1:0]         rom_duration,
  output logic [SONG_W+NOTE_W-1:0] rom_addr,
  output logic [NOTE_CODE_W-1:0]   note,
  output logic [DUR_W-1:0]         duration,
  output logic                     load_new_note,
  output logic                     playing,
  output logic                     song_end,
  output logic [SONG_W-1:0]        song
);

  localparam logic [NOTE_W-1:0] NOTE_MAX = '1;

  state_e              state_q, state_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic [NOTE_W-1:0]   note_idx_q, note_idx_d;
  note_t               note_q, note_d;
  logic                load_q, load_d;
  logic                song_end_q, song_end_d;
  logic                playing_q, playing_d;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PAUSED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; next outranks everything and is honoured in every state.
  always_comb begin
    state_d = state_q;
    if (next) begin
      state_d = (state_q == S_PAUSED) ? S_PAUSED : S_FETCH;
    end else begin
      case (state_q)
        S_PAUSED:  if (play) state_d = S_FETCH;
        S_FETCH:   state_d = S_LOAD;
        S_LOAD:    state_d = (rom_duration == '0) ? S_END : S_PLAYING;
        S_PLAYING: begin
          if (play) begin
            state_d = S_PAUSED;
          end else if (note_done) begin
            // Last slot of a song ends it rather than wrapping to note 0.
            state_d = (note_idx_q == NOTE_MAX) ? S_END : S_FETCH;
          end
        end
        S_END:     state_d = S_PAUSED;
        default:   state_d = S_PAUSED;
      endcase
    end
  end

  // Datapath and output next values.
  always_comb begin
    song_d     = song_q;
    note_idx_d = note_idx_q;
    note_d     = note_q;
    load_d     = 1'b0;
    song_end_d = 1'b0;
    if (next) begin
      song_d     = song_q + SONG_W'(1);
      note_idx_d = '0;
      note_d     = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (rom_duration != '0) begin
            note_d = '{note: rom_note, duration: rom_duration};
            load_d = 1'b1;
          end
        end
        S_PLAYING: begin
          // Pausing keeps note_idx so resume replays the current note.
          if (play) begin
            note_d = '0;
          end else if (note_done && (note_idx_q != NOTE_MAX)) begin
            note_idx_d = note_idx_q + NOTE_W'(1);
          end
        end
        S_END: begin
          song_d     = song_q + SONG_W'(1);
          note_idx_d = '0;
          note_d     = '0;
          song_end_d = 1'b1;
        end
        default: ;
      endcase
    end
    playing_d = (state_d != S_PAUSED);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      song_q     <= '0;
      note_idx_q <= '0;
      note_q     <= '0;
      load_q     <= 1'b0;
      song_end_q <= 1'b0;
      playing_q  <= 1'b0;
    end else begin
      song_q     <= song_d;
      note_idx_q <= note_idx_d;
      note_q     <= note_d;
      load_q     <= load_d;
      song_end_q <= song_end_d;
      playing_q  <= playing_d;
    end
  end

  assign rom_addr      = {song_q, note_idx_q};
  assign note          = note_q.note;
  assign duration      = note_q.duration;
  assign load_new_note = load_q;
  assign song_end      = song_end_q;
  assign playing       = playing_q;
  assign song          = song_q;

endmodule : song_controller
